// File: rtl/vga_timing_ctrl_if.sv
// Video timing bundle from vga_timing_ctrl to the pixel/colour blocks.
// master: timing controller drives; slave: colour generators consume.
interface vga_timing_ctrl_if;
    logic [10:0] x;
    logic [10:0] y;
    logic        disp_en;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        output x, y, disp_en, hsync, vsync,
        output line_start, frame_start, frame_cnt
    );

    modport slave (
        input x, y, disp_en, hsync, vsync,
        input line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Pixel timing generator, 1280x1024@60 by default.
// Ports: VGA_CLK, reset (sync, active high), vga (timing bundle, master).
module vga_timing_ctrl #(
    parameter int H_VIS    = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_VIS    = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter bit SYNC_POL = 1'b1,
    parameter int PIX_DLY  = 1
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    vga_timing_ctrl_if.master  vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Bounds are 12 bits wide so an end bound of 2048 stays representable.
    localparam logic [11:0] H_VIS_B = 12'(H_VIS);
    localparam logic [11:0] HS_BEG  = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] V_VIS_B = 12'(V_VIS);
    localparam logic [11:0] VS_BEG  = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_VIS + V_FP + V_SYNC);

    localparam bit ACT  = SYNC_POL;
    localparam bit IDLE = !SYNC_POL;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [7:0]  fr_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic        raw_hs;
    logic        raw_vs;

    logic [10:0] x_q;
    logic [10:0] y_q;
    logic        de_q;
    logic        ls_q;
    logic        fs_q;
    logic [7:0]  fc_q;
    logic        hs_q;
    logic        vs_q;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign raw_hs = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign raw_vs = (v_ext >= VS_BEG) && (v_ext < VS_END);

    // fr_cnt steps on the wrap edge; its registered copy then lines up
    // with frame_start one clock later, like every other output.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            fr_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? 11'd0 : h_cnt + 11'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
            end
            if (h_wrap && v_wrap) begin
                fr_cnt <= fr_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            fc_q <= '0;
            hs_q <= IDLE;
            vs_q <= IDLE;
        end else begin
            x_q  <= h_cnt;
            y_q  <= v_cnt;
            de_q <= (h_ext < H_VIS_B) && (v_ext < V_VIS_B);
            ls_q <= (h_cnt == 11'd0);
            fs_q <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
            fc_q <= fr_cnt;
            hs_q <= raw_hs ? ACT : IDLE;
            vs_q <= raw_vs ? ACT : IDLE;
        end
    end

    // Extra sync stages match the colour pipeline of downstream blocks.
    if (PIX_DLY > 0) begin : g_dly
        logic [PIX_DLY-1:0] hs_dly;
        logic [PIX_DLY-1:0] vs_dly;
        logic [PIX_DLY:0]   hs_cat;
        logic [PIX_DLY:0]   vs_cat;

        // New sample enters at the top; bit 0 is the oldest.
        assign hs_cat = {hs_q, hs_dly};
        assign vs_cat = {vs_q, vs_dly};

        always_ff @(posedge VGA_CLK) begin
            if (reset) begin
                hs_dly <= {PIX_DLY{IDLE}};
                vs_dly <= {PIX_DLY{IDLE}};
            end else begin
                hs_dly <= hs_cat[PIX_DLY:1];
                vs_dly <= vs_cat[PIX_DLY:1];
            end
        end

        assign vga.hsync = hs_dly[0];
        assign vga.vsync = vs_dly[0];
    end else begin : g_nodly
        assign vga.hsync = hs_q;
        assign vga.vsync = vs_q;
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.disp_en     = de_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
    assign vga.frame_cnt   = fc_q;

endmodule
